// File: rtl/vend_fsm_param.sv
// Parameterised vending controller: accepts 1/2/5-unit coins, vends at PRICE, refunds on cancel.
// Optional idle auto-refund is compiled in with `define VEND_TIMEOUT_EN.
module vend_fsm_param #(
  parameter int unsigned PRICE    = 8,
  parameter int unsigned CREDIT_W = 4,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                one,
  input  logic                two,
  input  logic                five,
  input  logic                cancel,
  output logic                goods,
  output logic [CREDIT_W-1:0] change,
  output logic [CREDIT_W-1:0] credit,
  output logic                reject
);

  typedef enum logic [1:0] {IDLE, ACCUM, VEND, REFUND} state_t;

  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);

  state_t              state;
  logic [CREDIT_W-1:0] coin_val;
  logic [CREDIT_W-1:0] sum;
  logic                any_coin;
  logic                multi_coin;
  logic                timeout_hit;

  // Priority one > two > five; only the winning coin contributes value.
  always_comb begin
    coin_val = '0;
    if (one)       coin_val = CREDIT_W'(1);
    else if (two)  coin_val = CREDIT_W'(2);
    else if (five) coin_val = CREDIT_W'(5);
  end

  assign any_coin   = one | two | five;
  assign multi_coin = (one & two) | (one & five) | (two & five);
  assign sum        = credit + coin_val;

`ifdef VEND_TIMEOUT_EN
  localparam int unsigned TO_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [TO_W-1:0] idle_cnt;

  assign timeout_hit = (state == ACCUM) && (idle_cnt == TO_W'(TIMEOUT));

  // Counts quiet ACCUM cycles; any other situation (coin, cancel, leaving ACCUM) clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
    end else if (state == ACCUM && !any_coin && !cancel && !timeout_hit) begin
      idle_cnt <= idle_cnt + TO_W'(1);
    end else begin
      idle_cnt <= '0;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      goods  <= 1'b0;
      change <= '0;
      credit <= '0;
      reject <= 1'b0;
    end else begin
      goods  <= 1'b0;
      change <= '0;
      reject <= 1'b0;
      case (state)
        IDLE, ACCUM: begin
          if (state == ACCUM && cancel) begin
            // Cancel beats a simultaneous coin; the coin is bounced, not refunded.
            state  <= REFUND;
            change <= credit;
            credit <= '0;
            reject <= any_coin;
          end else if (any_coin) begin
            reject <= multi_coin;
            if (sum >= PRICE_C) begin
              state  <= VEND;
              goods  <= 1'b1;
              change <= sum - PRICE_C;
              credit <= '0;
            end else begin
              state  <= ACCUM;
              credit <= sum;
            end
          end else if (timeout_hit) begin
            state  <= REFUND;
            change <= credit;
            credit <= '0;
          end
        end
        default: begin
          state  <= IDLE;
          reject <= any_coin;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vend_fsm_param.sv
// Self-checking bench for vend_fsm_param: directed scenarios plus random coins against a credit-level model.
module tb_vend_fsm_param;

  localparam int unsigned PRICE    = 8;
  localparam int unsigned CW       = 4;
  localparam int unsigned TIMEOUT  = 16;

  logic          clk;
  logic          rst_n;
  logic          one, two, five, cancel;
  logic          goods;
  logic [CW-1:0] change;
  logic [CW-1:0] credit;
  logic          reject;

  int n_checks;
  int n_fail;

  // Model state: credit held, whether last cycle was a vend/refund pulse, quiet-cycle count.
  int m_credit;
  bit m_busy;
  int m_idle;
  bit e_goods;
  int e_change;
  int e_credit;
  bit e_reject;

  vend_fsm_param #(
    .PRICE   (PRICE),
    .CREDIT_W(CW),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .one   (one),
    .two   (two),
    .five  (five),
    .cancel(cancel),
    .goods (goods),
    .change(change),
    .credit(credit),
    .reject(reject)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_credit = 0;
    m_busy   = 1'b0;
    m_idle   = 0;
    e_goods  = 1'b0;
    e_change = 0;
    e_credit = 0;
    e_reject = 1'b0;
  endtask

  task automatic model_step(input bit o, input bit t, input bit f, input bit c);
    int ncoins;
    int val;
    ncoins   = int'(o) + int'(t) + int'(f);
    val      = o ? 1 : (t ? 2 : (f ? 5 : 0));
    e_goods  = 1'b0;
    e_change = 0;
    e_reject = 1'b0;
    if (m_busy) begin
      m_busy   = 1'b0;
      e_reject = (ncoins > 0);
    end else if (m_credit > 0 && c) begin
      e_change = m_credit;
      m_credit = 0;
      m_busy   = 1'b1;
      m_idle   = 0;
      e_reject = (ncoins > 0);
    end else if (ncoins > 0) begin
      e_reject = (ncoins > 1);
      m_idle   = 0;
      if (m_credit + val >= PRICE) begin
        e_goods  = 1'b1;
        e_change = m_credit + val - PRICE;
        m_credit = 0;
        m_busy   = 1'b1;
      end else begin
        m_credit = m_credit + val;
      end
    end else if (m_credit > 0) begin
`ifdef VEND_TIMEOUT_EN
      if (m_idle == TIMEOUT) begin
        e_change = m_credit;
        m_credit = 0;
        m_busy   = 1'b1;
        m_idle   = 0;
      end else begin
        m_idle = m_idle + 1;
      end
`endif
    end
    e_credit = m_credit;
  endtask

  // Drives one cycle of inputs, waits past the edge, and advances the model.
  task automatic drive_step(input bit o, input bit t, input bit f, input bit c);
    one    = o;
    two    = t;
    five   = f;
    cancel = c;
    @(posedge clk);
    #1;
    model_step(o, t, f, c);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    one = 1'b0; two = 1'b0; five = 1'b0; cancel = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if ({goods, change, credit, reject} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: goods=%b change=%0d credit=%0d reject=%b, want all 0",
               goods, change, credit, reject);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_eight_ones();
    for (int i = 1; i <= 8; i++) begin
      drive_step(1, 0, 0, 0);
      n_checks++;
      if ({goods, change, credit, reject} !== {e_goods, e_change[CW-1:0], e_credit[CW-1:0], e_reject}) begin
        n_fail++;
        $display("FAIL eight_ones[%0d]: got g=%b ch=%0d cr=%0d rj=%b want g=%b ch=%0d cr=%0d rj=%b",
                 i, goods, change, credit, reject, e_goods, e_change, e_credit, e_reject);
      end
    end
    n_checks++;
    if (goods !== 1'b1 || change !== 4'd0 || credit !== 4'd0) begin
      n_fail++;
      $display("FAIL eight_ones_vend: goods=%b change=%0d credit=%0d, want 1 0 0", goods, change, credit);
    end
    drive_step(0, 0, 0, 0);
    n_checks++;
    if (goods !== 1'b0 || change !== 4'd0) begin
      n_fail++;
      $display("FAIL eight_ones_after: goods=%b change=%0d, want 0 0", goods, change);
    end
  endtask

  task automatic test_change_amounts();
    drive_step(0, 0, 1, 0);
    drive_step(0, 0, 1, 0);
    n_checks++;
    if (goods !== 1'b1 || change !== 4'd2 || credit !== 4'd0) begin
      n_fail++;
      $display("FAIL five_five: goods=%b change=%0d credit=%0d, want 1 2 0", goods, change, credit);
    end
    drive_step(0, 0, 0, 0);
    drive_step(0, 0, 1, 0);
    drive_step(0, 1, 0, 0);
    n_checks++;
    if (credit !== 4'd7 || goods !== 1'b0) begin
      n_fail++;
      $display("FAIL five_two_credit: credit=%0d goods=%b, want 7 0", credit, goods);
    end
    drive_step(0, 0, 1, 0);
    n_checks++;
    if (goods !== 1'b1 || change !== 4'd4 || credit !== 4'd0) begin
      n_fail++;
      $display("FAIL five_two_five: goods=%b change=%0d credit=%0d, want 1 4 0", goods, change, credit);
    end
    drive_step(0, 0, 0, 0);
  endtask

  task automatic test_cancel();
    drive_step(0, 1, 0, 0);
    drive_step(0, 0, 0, 1);
    n_checks++;
    if ({goods, change, credit, reject} !== {1'b0, 4'd2, 4'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL cancel_refund: got g=%b ch=%0d cr=%0d rj=%b want 0 2 0 0", goods, change, credit, reject);
    end
    drive_step(0, 0, 0, 0);
    n_checks++;
    if (change !== 4'd0) begin
      n_fail++;
      $display("FAIL cancel_pulse_end: change=%0d, want 0", change);
    end
    drive_step(0, 1, 0, 0);
    drive_step(1, 0, 0, 1);
    n_checks++;
    if ({goods, change, credit, reject} !== {1'b0, 4'd2, 4'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL cancel_with_coin: got g=%b ch=%0d cr=%0d rj=%b want 0 2 0 1", goods, change, credit, reject);
    end
    drive_step(0, 0, 0, 0);
    // Cancel in IDLE must not disturb anything; a coin alongside it is accepted.
    drive_step(0, 0, 0, 1);
    n_checks++;
    if ({goods, change, credit, reject} !== '0) begin
      n_fail++;
      $display("FAIL cancel_idle: got g=%b ch=%0d cr=%0d rj=%b want all 0", goods, change, credit, reject);
    end
    drive_step(0, 1, 0, 1);
    n_checks++;
    if (credit !== 4'd2 || change !== 4'd0 || reject !== 1'b0) begin
      n_fail++;
      $display("FAIL cancel_idle_coin: credit=%0d change=%0d reject=%b, want 2 0 0", credit, change, reject);
    end
    drive_step(0, 0, 0, 1);
    drive_step(0, 0, 0, 0);
  endtask

  task automatic test_reject();
    drive_step(1, 0, 1, 0);
    n_checks++;
    if (credit !== 4'd1 || reject !== 1'b1) begin
      n_fail++;
      $display("FAIL multi_coin: credit=%0d reject=%b, want 1 1", credit, reject);
    end
    drive_step(0, 0, 0, 0);
    n_checks++;
    if (reject !== 1'b0 || credit !== 4'd1) begin
      n_fail++;
      $display("FAIL multi_coin_pulse: reject=%b credit=%0d, want 0 1", reject, credit);
    end
    drive_step(0, 0, 1, 0);
    drive_step(0, 1, 0, 0);
    n_checks++;
    if (goods !== 1'b1 || change !== 4'd0) begin
      n_fail++;
      $display("FAIL exact_price: goods=%b change=%0d, want 1 0", goods, change);
    end
    drive_step(1, 0, 0, 1);
    n_checks++;
    if ({goods, change, credit, reject} !== {1'b0, 4'd0, 4'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL coin_in_vend: got g=%b ch=%0d cr=%0d rj=%b want 0 0 0 1", goods, change, credit, reject);
    end
    drive_step(0, 0, 0, 0);
    n_checks++;
    if ({goods, change, credit, reject} !== {e_goods, e_change[CW-1:0], e_credit[CW-1:0], e_reject}) begin
      n_fail++;
      $display("FAIL reject_settle: got g=%b ch=%0d cr=%0d rj=%b want g=%b ch=%0d cr=%0d rj=%b",
               goods, change, credit, reject, e_goods, e_change, e_credit, e_reject);
    end
  endtask

  task automatic test_timeout();
    drive_step(0, 1, 0, 0);
    for (int i = 1; i <= int'(TIMEOUT) + 2; i++) begin
      drive_step(0, 0, 0, 0);
      n_checks++;
      if ({goods, change, credit, reject} !== {e_goods, e_change[CW-1:0], e_credit[CW-1:0], e_reject}) begin
        n_fail++;
        $display("FAIL timeout[%0d]: got g=%b ch=%0d cr=%0d rj=%b want g=%b ch=%0d cr=%0d rj=%b",
                 i, goods, change, credit, reject, e_goods, e_change, e_credit, e_reject);
      end
`ifdef VEND_TIMEOUT_EN
      if (i == int'(TIMEOUT) + 1) begin
        n_checks++;
        if (change !== 4'd2 || credit !== 4'd0) begin
          n_fail++;
          $display("FAIL timeout_refund: change=%0d credit=%0d, want 2 0", change, credit);
        end
      end
`else
      if (i == int'(TIMEOUT) + 1) begin
        n_checks++;
        if (credit !== 4'd2 || change !== 4'd0) begin
          n_fail++;
          $display("FAIL timeout_hold: credit=%0d change=%0d, want 2 0", credit, change);
        end
      end
`endif
    end
    drive_step(0, 0, 0, 1);
    drive_step(0, 0, 0, 0);
  endtask

  task automatic test_async_reset();
    drive_step(0, 0, 1, 0);
    n_checks++;
    if (credit !== 4'd5) begin
      n_fail++;
      $display("FAIL pre_reset_credit: credit=%0d, want 5", credit);
    end
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if ({goods, change, credit, reject} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got g=%b ch=%0d cr=%0d rj=%b want all 0", goods, change, credit, reject);
    end
    one = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if ({goods, change, credit, reject} !== '0) begin
      n_fail++;
      $display("FAIL reset_hold: got g=%b ch=%0d cr=%0d rj=%b want all 0", goods, change, credit, reject);
    end
    #3;
    rst_n = 1'b1;
    drive_step(1, 0, 0, 0);
    n_checks++;
    if (credit !== 4'd1 || goods !== 1'b0 || change !== 4'd0) begin
      n_fail++;
      $display("FAIL first_edge_coin: credit=%0d goods=%b change=%0d, want 1 0 0", credit, goods, change);
    end
    drive_step(0, 0, 0, 1);
    drive_step(0, 0, 0, 0);
  endtask

  task automatic test_random();
    bit o, t, f, c;
    for (int i = 0; i < 400; i++) begin
      o = ($urandom_range(0, 99) < 25);
      t = ($urandom_range(0, 99) < 25);
      f = ($urandom_range(0, 99) < 20);
      c = ($urandom_range(0, 99) < 8);
      drive_step(o, t, f, c);
      n_checks++;
      if ({goods, change, credit, reject} !== {e_goods, e_change[CW-1:0], e_credit[CW-1:0], e_reject}) begin
        n_fail++;
        $display("FAIL random[%0d] in=%b%b%b%b: got g=%b ch=%0d cr=%0d rj=%b want g=%b ch=%0d cr=%0d rj=%b",
                 i, o, t, f, c, goods, change, credit, reject, e_goods, e_change, e_credit, e_reject);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_eight_ones();
    test_change_amounts();
    test_cancel();
    test_reject();
    test_timeout();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vend_fsm_param.md
VEND_FSM_PARAM -- requirements
Module: vend_fsm_param

Interface
REQ-001 Parameter: PRICE, 8, item price in coin units; legal range 2..(2**CREDIT_W - 5).
REQ-002 Parameter: CREDIT_W, 4, width of credit and change; SHALL satisfy PRICE+4 < 2**CREDIT_W.
REQ-003 Parameter: TIMEOUT, 16, idle cycles before auto-refund; used only with VEND_TIMEOUT_EN.
REQ-004 Port: clk  input  1  single system clock, rising edge.
REQ-005 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-006 Port: one  input  1  1-unit coin present this cycle.
REQ-007 Port: two  input  1  2-unit coin present this cycle.
REQ-008 Port: five  input  1  5-unit coin present this cycle.
REQ-009 Port: cancel  input  1  customer refund request.
REQ-010 Port: goods  output  1  registered 1-cycle vend pulse.
REQ-011 Port: change  output  CREDIT_W  registered change or refund amount, valid while goods or refund pulse is active, else 0.
REQ-012 Port: credit  output  CREDIT_W  registered accumulated credit.
REQ-013 Port: reject  output  1  registered 1-cycle pulse: at least one coin was not accepted in the previous cycle.

Function
REQ-014 States SHALL be IDLE, ACCUM, VEND and REFUND; all outputs SHALL be registered.
REQ-015 Coin value: one=1, two=2, five=5; when several coins are asserted, priority is one > two > five; only the winning coin is accepted and reject SHALL pulse.
REQ-016 IDLE/ACCUM, accepted coin, sum = credit + value < PRICE: next state ACCUM, credit = sum, goods = 0, change = 0.
REQ-017 IDLE/ACCUM, accepted coin, sum >= PRICE: next state VEND, goods = 1, change = sum - PRICE, credit = 0; latency is 1 cycle after the coin edge.
REQ-018 VEND and REFUND SHALL last exactly 1 cycle, then go to IDLE with goods = 0 and change = 0.
REQ-019 Coins asserted in VEND or REFUND SHALL be rejected: reject pulses and credit is not changed.
REQ-020 ACCUM with cancel: next state REFUND, change = credit, goods = 0, credit = 0.
REQ-021 Cancel and a coin in the same ACCUM cycle: cancel wins, the coin is rejected, and the refund excludes that coin.
REQ-022 Cancel in IDLE, VEND or REFUND SHALL have no effect.
REQ-023 With no coin and no cancel, the state and credit SHALL hold; credit SHALL never exceed PRICE-1 outside VEND.
REQ-024 Arithmetic SHALL be unsigned, CREDIT_W bits wide, with no overflow under the constraint in REQ-002.

Reset
REQ-025 rst_n low SHALL immediately force IDLE with goods = 0, change = 0, credit = 0, reject = 0 and the timeout counter = 0, independent of clk.
REQ-026 Reset asserted mid-operation SHALL discard credit with no refund pulse.
REQ-027 Coins sampled on the first rising edge after rst_n deasserts SHALL be processed normally.

Configuration
REQ-028 Macro: VEND_TIMEOUT_EN.
REQ-029 Defined: a counter increments on each ACCUM cycle with no coin and no cancel, and clears on an accepted coin or on leaving ACCUM.
REQ-030 Defined: when the counter reaches TIMEOUT, the next state is REFUND with change = credit; the refund pulse occurs TIMEOUT+1 edges after the last coin.
REQ-031 Not defined: no counter logic is present and ACCUM holds indefinitely; the TIMEOUT parameter is unused.

Verification
REQ-032 Scenario (PRICE=8): eight consecutive "one" coins -> the cycle after the 8th shows goods=1, change=0, credit=0; the following cycle shows goods=0.
REQ-033 Scenario: five, five -> goods=1, change=2.
REQ-034 Scenario: five, two, five (credit 7+5) -> goods=1, change=4.
REQ-035 Scenario: two, then cancel -> change=2, goods=0, credit=0; cancel+one in the same cycle with credit 2 -> refund 2, reject=1.
REQ-036 Scenario: one and five asserted together from IDLE -> credit=1, reject=1 for one cycle; a coin during VEND -> reject=1 and credit stays 0.
REQ-037 Scenario: two, then 16 idle cycles -> macro defined: refund change=2; macro undefined: credit stays 2. Also, rst_n low at credit 5 -> all outputs 0 asynchronously.
